inst_encoder: RTL and testbench
===============================

# inst_encoder

Instruction encoder for the RV32I core's test and boot infrastructure, the inverse of the immediate generator. It accepts decoded instruction fields: opcode, register indices, funct fields, and a full 32-bit signed immediate. It range-checks the immediate for the selected format, scatters the bits into a 32-bit instruction word, and delivers the result through a small output FIFO with a valid/ready handshake. Typical consumers are the instruction-memory loader and self-checking benches that round-trip encoder output through the immediate generator.

## Interface
Parameters:
- DEPTH, 2, output FIFO entries, ≥1
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept an input this cycle
- in_opcode  in  7  instruction opcode
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field, R-type only
- in_imm  in  32  signed immediate, byte offset for B and J
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts the head
- out_inst  out  32  encoded instruction at the FIFO head
- out_err  out  1  head entry failed its range or opcode check
- enc_count  out  CNT_W  number of accepted inputs, saturating
- err_count  out  CNT_W  number of accepted inputs with an error, saturating

## Operation
- Format is selected by opcode:
  - I-type: 0000011, 0010011, 1100111
  - S-type: 0100011
  - B-type: 1100011
  - J-type: 1101111
  - R-type: 0110011
  - Any other opcode is an error.
- Packing:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; in_imm is ignored.
- Unused fields of each format are ignored.
- I-type shifts need no special case: the caller places funct7 in imm[11:5].
- Range checks:
  - I and S: imm[31:11] must all be equal.
  - B: imm[31:12] must all be equal, and imm[0] must be 0.
  - J: imm[31:20] must all be equal, and imm[0] must be 0.
- On any error, the entry stores out_inst = 32'h0000_0013 (NOP) with out_err = 1.
- FIFO behaviour:
  - An input is accepted when in_valid && in_ready; the encoded word and error flag are pushed.
  - The head is popped when out_valid && out_ready.
  - Entries leave in order; there is no drop and no duplication.
- in_ready = (occupancy < DEPTH). It is registered-state based and does not depend combinationally on out_ready.
- Counters:
  - enc_count increments on every accept.
  - err_count increments on every accept with an error.
  - Both saturate at all-ones.
- Reset (asynchronous, rst_n = 0) forces:
  - FIFO empty, so out_valid = 0
  - out_inst = 0 and out_err = 0
  - in_ready = 0 while reset is asserted, 1 after release
  - enc_count = 0 and err_count = 0
  - In-flight entries are discarded.

## Timing
- Latency is 1 cycle: an input accepted at edge N is visible on out_* after edge N when the FIFO was empty.
- Throughput is 1 instruction per cycle when out_ready is held high.
- out_inst and out_err are held stable while out_valid && !out_ready.
- When empty, out_inst and out_err show the last popped value, or 0 after reset.
- Simultaneous push and pop when not full: occupancy is unchanged and the order is preserved.
- Full with out_ready = 1: the pop occurs and in_ready rises the next cycle. No pass-through on the same cycle.
- Empty with push: out_valid rises the next cycle. No combinational bypass.
- in_valid while in_ready = 0: the input is not accepted, and the counters are unchanged.

## Test plan
- addi x1,x0,-1: opcode 0010011, rd=1, funct3=0, imm=0xFFFFFFFF -> out_inst 0xFFF00093, out_err 0.
- sw x2,8(x1): opcode 0100011, funct3=010, rs1=1, rs2=2, imm=8 -> 0x0020A423. Then beq x0,x0,-4 (imm=0xFFFFFFFC) -> 0xFE000EE3. Then jal x1,+2048 (rd=1, imm=0x800) -> 0x001000EF.
- Errors:
  - addi with imm=2048 -> 0x00000013, out_err 1, err_count 1.
  - beq with imm=3 -> error.
  - opcode 0000000 -> error.
  - jal with imm=0x00100000 -> error.
- Backpressure with DEPTH=2 and out_ready=0: push three valid inputs.
  - in_ready drops after 2 accepts; the third is held.
  - After out_ready=1, outputs appear in order, followed by the third.
  - enc_count = 3.
- Streaming: out_ready=1 and 100 random legal instructions back-to-back. Each output must pass through the immediate generator and reproduce the sign-extended imm, with an even value for B/J. One output per cycle after the first.
- Reset mid-operation: FIFO holding 2 entries, rst_n pulsed low asynchronously -> out_valid 0, both counters 0, out_inst 0 immediately. Normal accept resumes the cycle after release.

Source files
------------

// File: rtl/inst_encoder.sv
`default_nettype none
// inst_encoder: packs decoded RV32I fields into an instruction word, range-checks
// the immediate, and queues {word, error} in a small in-order FIFO.
module inst_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [OW-1:0] FULL = OW'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [31:0]   NOP  = 32'h0000_0013;

    typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_J, FMT_R, FMT_BAD} fmt_t;

    fmt_t        fmt;
    logic [31:0] packed_inst;
    logic [31:0] enc_inst;
    logic        range_ok;
    logic        enc_err;

    always_comb begin
        case (in_opcode)
            7'b0000011, 7'b0010011, 7'b1100111: fmt = FMT_I;
            7'b0100011:                         fmt = FMT_S;
            7'b1100011:                         fmt = FMT_B;
            7'b1101111:                         fmt = FMT_J;
            7'b0110011:                         fmt = FMT_R;
            default:                            fmt = FMT_BAD;
        endcase
    end

    // Range check: the bits above the format's sign bit must replicate it.
    always_comb begin
        packed_inst = '0;
        range_ok    = 1'b0;
        case (fmt)
            FMT_I: begin
                packed_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                range_ok    = (&in_imm[31:11]) | ~(|in_imm[31:11]);
            end
            FMT_S: begin
                packed_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                range_ok    = (&in_imm[31:11]) | ~(|in_imm[31:11]);
            end
            FMT_B: begin
                packed_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], in_opcode};
                range_ok    = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
            end
            FMT_J: begin
                packed_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                range_ok    = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
            end
            FMT_R: begin
                packed_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                range_ok    = 1'b1;
            end
            default: begin
                packed_inst = '0;
                range_ok    = 1'b0;
            end
        endcase
        enc_err  = ~range_ok;
        enc_inst = enc_err ? NOP : packed_inst;
    end

    logic [31:0]   mem_inst [DEPTH];
    logic          mem_err  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] occ;
    logic [31:0]   last_inst;
    logic          last_err;
    logic          push;
    logic          pop;

    assign in_ready  = rst_n && (occ < FULL);
    assign out_valid = (occ != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // An empty FIFO keeps presenting the most recently popped entry.
    assign out_inst  = out_valid ? mem_inst[rd_ptr] : last_inst;
    assign out_err   = out_valid ? mem_err[rd_ptr]  : last_err;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= enc_inst;
            mem_err[wr_ptr]  <= enc_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            last_inst <= '0;
            last_err  <= 1'b0;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                if (enc_count != '1)
                    enc_count <= enc_count + 1'b1;
                if (enc_err && (err_count != '1))
                    err_count <= err_count + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
                last_inst <= mem_inst[rd_ptr];
                last_err  <= mem_err[rd_ptr];
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// tb_inst_encoder: directed and randomized checks of inst_encoder against a
// range/field model plus an immediate-generator round trip.
module tb_inst_encoder;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       in_opcode = '0;
    logic [4:0]       in_rd = '0;
    logic [4:0]       in_rs1 = '0;
    logic [4:0]       in_rs2 = '0;
    logic [2:0]       in_funct3 = '0;
    logic [6:0]       in_funct7 = '0;
    logic [31:0]      in_imm = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_inst;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    always #5 clk = ~clk;

    inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_err(out_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    typedef struct packed {
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fields_t;

    fields_t q[$];
    int checks = 0;
    int errors = 0;
    int exp_enc = 0;
    int exp_err = 0;

    function automatic fields_t mk(input logic [6:0] opc, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] imm);
        fields_t f;
        f.opc = opc; f.rd = rd; f.rs1 = rs1; f.rs2 = rs2;
        f.f3 = f3; f.f7 = f7; f.imm = imm;
        return f;
    endfunction

    // 0=I 1=S 2=B 3=J 4=R, -1 unknown
    function automatic int kind(input logic [6:0] opc);
        case (opc)
            7'b0000011, 7'b0010011, 7'b1100111: return 0;
            7'b0100011: return 1;
            7'b1100011: return 2;
            7'b1101111: return 3;
            7'b0110011: return 4;
            default:    return -1;
        endcase
    endfunction

    function automatic bit legal(input fields_t f);
        int s;
        s = $signed(f.imm);
        case (kind(f.opc))
            0, 1:    return (s >= -2048) && (s <= 2047);
            2:       return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            3:       return (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
            4:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] imm_gen(input logic [31:0] i, input int k);
        case (k)
            0:       return {{20{i[31]}}, i[31:20]};
            1:       return {{20{i[31]}}, i[31:25], i[11:7]};
            2:       return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3:       return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit fields_ok(input fields_t f, input logic [31:0] inst);
        int k;
        k = kind(f.opc);
        if (inst[6:0] !== f.opc) return 1'b0;
        if (k != 3 && inst[14:12] !== f.f3) return 1'b0;
        if ((k == 0 || k == 3 || k == 4) && inst[11:7] !== f.rd) return 1'b0;
        if (k != 3 && inst[19:15] !== f.rs1) return 1'b0;
        if ((k == 1 || k == 2 || k == 4) && inst[24:20] !== f.rs2) return 1'b0;
        if (k == 4) return inst[31:25] === f.f7;
        return imm_gen(inst, k) === f.imm;
    endfunction

    function automatic fields_t rand_legal();
        fields_t f;
        int v;
        f = mk(7'h0, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), 32'h0);
        case ($urandom_range(0, 4))
            0: begin
                case ($urandom_range(0, 2))
                    0:       f.opc = 7'b0000011;
                    1:       f.opc = 7'b0010011;
                    default: f.opc = 7'b1100111;
                endcase
                v = int'($urandom_range(0, 4095)) - 2048;
            end
            1: begin f.opc = 7'b0100011; v = int'($urandom_range(0, 4095)) - 2048; end
            2: begin f.opc = 7'b1100011; v = (int'($urandom_range(0, 4095)) - 2048) * 2; end
            3: begin f.opc = 7'b1101111; v = (int'($urandom_range(0, 1048575)) - 524288) * 2; end
            default: begin f.opc = 7'b0110011; v = int'($urandom); end
        endcase
        f.imm = v;
        return f;
    endfunction

    function automatic fields_t rand_any();
        fields_t f;
        f = rand_legal();
        case ($urandom_range(0, 3))
            0:       f.imm = $urandom;
            1:       f.opc = 7'($urandom_range(0, 127));
            default: ;
        endcase
        return f;
    endfunction

    // Drive one cycle, update the scoreboard, and report what was accepted/popped.
    task automatic drive_cycle(input fields_t f, input bit v, input bit ordy,
                               output bit acc, output bit pop, output bit had,
                               output logic [31:0] gi, output logic gerr,
                               output fields_t ef, output bit eerr);
        in_valid = v; out_ready = ordy;
        in_opcode = f.opc; in_rd = f.rd; in_rs1 = f.rs1; in_rs2 = f.rs2;
        in_funct3 = f.f3; in_funct7 = f.f7; in_imm = f.imm;
        acc = v && (in_ready === 1'b1);
        pop = ordy && (out_valid === 1'b1);
        gi = out_inst; gerr = out_err;
        had = 1'b0; ef = '0; eerr = 1'b0;
        if (pop && q.size() > 0) begin
            ef = q.pop_front();
            eerr = !legal(ef);
            had = 1'b1;
        end
        @(posedge clk); #1;
        if (acc) begin
            q.push_back(f);
            if (exp_enc < 65535) exp_enc++;
            if (!legal(f) && exp_err < 65535) exp_err++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_inst !== 32'h0 || out_err !== 1'b0 ||
            enc_count !== '0 || err_count !== '0) begin
            errors++;
            $display("FAIL reset_state got valid=%b ready=%b inst=%h err=%b enc=%0d errc=%0d exp 0 0 0 0 0 0",
                     out_valid, in_ready, out_inst, out_err, enc_count, err_count);
        end
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b valid=%b exp 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        fields_t     vec [10];
        logic [31:0] word [10];
        bit          werr [10];
        bit acc, pop, had, eerr;
        logic [31:0] gi;
        logic gerr;
        fields_t ef;
        vec[0] = mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF); word[0] = 32'hFFF0_0093; werr[0] = 0;
        vec[1] = mk(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);         word[1] = 32'h0020_A423; werr[1] = 0;
        vec[2] = mk(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFC); word[2] = 32'hFE00_0EE3; werr[2] = 0;
        vec[3] = mk(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_0800); word[3] = 32'h0010_00EF; werr[3] = 0;
        vec[4] = mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048);      word[4] = NOP;           werr[4] = 1;
        vec[5] = mk(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3);         word[5] = NOP;           werr[5] = 1;
        vec[6] = mk(7'b0000000, 5'd3, 5'd4, 5'd5, 3'b001, 7'd0, 32'd0);         word[6] = NOP;           werr[6] = 1;
        vec[7] = mk(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0010_0000); word[7] = NOP;           werr[7] = 1;
        vec[8] = mk(7'b0010011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_F800); word[8] = 32'h8000_0013; werr[8] = 0;
        vec[9] = mk(7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFF0_0000); word[9] = 32'h8000_006F; werr[9] = 0;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(vec[i], 1'b1, 1'b1, acc, pop, had, gi, gerr, ef, eerr);
            checks++;
            if (!acc) begin errors++; $display("FAIL directed_accept[%0d] got ready=0 exp 1", i); end
            drive_cycle(vec[i], 1'b0, 1'b1, acc, pop, had, gi, gerr, ef, eerr);
            checks++;
            if (!pop || gi !== word[i] || gerr !== werr[i]) begin
                errors++;
                $display("FAIL directed_word[%0d] got valid=%b inst=%h err=%b exp 1 %h %b",
                         i, pop, gi, gerr, word[i], werr[i]);
            end
            checks++;
            if (out_valid !== 1'b0 || out_inst !== word[i] || out_err !== werr[i] ||
                err_count !== CNT_W'(exp_err) || enc_count !== CNT_W'(exp_enc)) begin
                errors++;
                $display("FAIL directed_after[%0d] got valid=%b inst=%h err=%b enc=%0d errc=%0d exp 0 %h %b %0d %0d",
                         i, out_valid, out_inst, out_err, enc_count, err_count, word[i], werr[i], exp_enc, exp_err);
            end
        end
    endtask

    task automatic test_backpressure();
        fields_t v [3];
        fields_t idle;
        bit acc, pop, had, eerr, first;
        logic [31:0] gi, hold;
        logic gerr;
        fields_t ef;
        int idx;
        idle = '0;
        for (int i = 0; i < 3; i++) v[i] = rand_legal();
        drive_cycle(v[0], 1'b1, 1'b0, acc, pop, had, gi, gerr, ef, eerr);
        checks++;
        if (!acc) begin errors++; $display("FAIL bp_accept0 got 0 exp 1"); end
        drive_cycle(v[1], 1'b1, 1'b0, acc, pop, had, gi, gerr, ef, eerr);
        checks++;
        if (!acc) begin errors++; $display("FAIL bp_accept1 got 0 exp 1"); end
        hold = gi;
        drive_cycle(v[2], 1'b1, 1'b0, acc, pop, had, gi, gerr, ef, eerr);
        checks++;
        if (acc || gi !== hold) begin
            errors++;
            $display("FAIL bp_full got accept=%b inst=%h exp 0 %h", acc, gi, hold);
        end
        idx = 2; first = 1'b1;
        for (int n = 0; n < 10 && (idx < 3 || q.size() > 0); n++) begin
            drive_cycle(idx < 3 ? v[idx] : idle, idx < 3, 1'b1, acc, pop, had, gi, gerr, ef, eerr);
            if (first) begin
                checks++;
                if (acc) begin errors++; $display("FAIL bp_no_passthru got accept=1 exp 0"); end
            end
            first = 1'b0;
            if (acc) idx++;
            if (pop) begin
                checks++;
                if (!had || gerr !== eerr || (eerr ? gi !== NOP : !fields_ok(ef, gi))) begin
                    errors++;
                    $display("FAIL bp_order got inst=%h err=%b exp opc=%h imm=%h err=%b",
                             gi, gerr, ef.opc, ef.imm, eerr);
                end
            end
        end
        checks++;
        if (idx != 3 || q.size() != 0 || enc_count !== CNT_W'(exp_enc)) begin
            errors++;
            $display("FAIL bp_drain got sent=%0d left=%0d enc=%0d exp 3 0 %0d", idx, q.size(), enc_count, exp_enc);
        end
    endtask

    task automatic test_stream();
        bit acc, pop, had, eerr;
        logic [31:0] gi;
        logic gerr;
        fields_t ef;
        for (int i = 0; i <= 100; i++) begin
            drive_cycle(rand_legal(), i < 100, 1'b1, acc, pop, had, gi, gerr, ef, eerr);
            if (i < 100) begin
                checks++;
                if (!acc) begin errors++; $display("FAIL stream_accept[%0d] got 0 exp 1", i); end
            end
            if (i > 0) begin
                checks++;
                if (!pop || !had || gerr !== 1'b0 || !fields_ok(ef, gi)) begin
                    errors++;
                    $display("FAIL stream_out[%0d] got valid=%b inst=%h err=%b exp opc=%h imm=%h err=0",
                             i, pop, gi, gerr, ef.opc, ef.imm);
                end
            end
        end
    endtask

    task automatic test_random_mix();
        bit acc, pop, had, eerr;
        logic [31:0] gi;
        logic gerr;
        fields_t ef;
        for (int i = 0; i < 320; i++) begin
            drive_cycle(rand_any(), (i < 300) && ($urandom_range(0, 3) != 0),
                        (i >= 300) || ($urandom_range(0, 2) != 0), acc, pop, had, gi, gerr, ef, eerr);
            if (pop) begin
                checks++;
                if (!had || gerr !== eerr || (eerr ? gi !== NOP : !fields_ok(ef, gi))) begin
                    errors++;
                    $display("FAIL mix_out[%0d] got inst=%h err=%b exp opc=%h imm=%h err=%b",
                             i, gi, gerr, ef.opc, ef.imm, eerr);
                end
            end
        end
        checks++;
        if (q.size() != 0 || out_valid !== 1'b0 || enc_count !== CNT_W'(exp_enc) || err_count !== CNT_W'(exp_err)) begin
            errors++;
            $display("FAIL mix_counts got left=%0d valid=%b enc=%0d errc=%0d exp 0 0 %0d %0d",
                     q.size(), out_valid, enc_count, err_count, exp_enc, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        bit acc, pop, had, eerr;
        logic [31:0] gi;
        logic gerr;
        fields_t ef, f;
        for (int i = 0; i < 2; i++)
            drive_cycle(rand_legal(), 1'b1, 1'b0, acc, pop, had, gi, gerr, ef, eerr);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_full got valid=%b ready=%b exp 1 0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_err !== 1'b0 || in_ready !== 1'b0 ||
            enc_count !== '0 || err_count !== '0) begin
            errors++;
            $display("FAIL rstmid_async got valid=%b inst=%h err=%b ready=%b enc=%0d errc=%0d exp 0 0 0 0 0 0",
                     out_valid, out_inst, out_err, in_ready, enc_count, err_count);
        end
        q.delete(); exp_enc = 0; exp_err = 0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        f = rand_legal();
        drive_cycle(f, 1'b1, 1'b1, acc, pop, had, gi, gerr, ef, eerr);
        checks++;
        if (!acc) begin errors++; $display("FAIL rstmid_resume got accept=0 exp 1"); end
        drive_cycle(f, 1'b0, 1'b1, acc, pop, had, gi, gerr, ef, eerr);
        checks++;
        if (!pop || !had || gerr !== 1'b0 || !fields_ok(f, gi) || enc_count !== 1) begin
            errors++;
            $display("FAIL rstmid_out got valid=%b inst=%h enc=%0d exp 1 opc=%h imm=%h 1",
                     pop, gi, enc_count, f.opc, f.imm);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_stream();
        test_random_mix();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
